ex_alu_issue: RTL and testbench

- ID/EX boundary block that drives the EX-stage ALU (i_ctr_code, i_data_a, i_data_b, CTR_BUS_WIDTH=4, codes per codes.vh).
- Decodes MIPS opcode/funct into the ALU control code and selects and extends operands.
- Registers the result once per accepted instruction, with stall and flush handling.
- Holds a sticky illegal-instruction flag and a bubble counter for the debug unit.

---
 rtl/ex_alu_issue.sv | 129 ++++++++++++
 tb/tb_ex_alu_issue.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ex_alu_issue.sv
// ID/EX issue stage: decodes MIPS opcode/funct into an ALU control code, selects
// and extends operands, and registers them with flush/stall handling and debug state.
module ex_alu_issue #(
  parameter int IO_BUS_WIDTH  = 32,
  parameter int CTR_BUS_WIDTH = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic                     i_stall,
  input  logic                     i_flush,
  input  logic [5:0]               i_opcode,
  input  logic [5:0]               i_funct,
  input  logic [4:0]               i_shamt,
  input  logic [15:0]              i_imm,
  input  logic [IO_BUS_WIDTH-1:0]  i_rs_data,
  input  logic [IO_BUS_WIDTH-1:0]  i_rt_data,
  output logic [CTR_BUS_WIDTH-1:0] o_ctr_code,
  output logic [IO_BUS_WIDTH-1:0]  o_data_a,
  output logic [IO_BUS_WIDTH-1:0]  o_data_b,
  output logic                     o_valid,
  output logic                     o_illegal,
  output logic [CNT_WIDTH-1:0]     o_bubble_cnt
);

  // ALU control codes shared with the EX-stage ALU.
  localparam logic [CTR_BUS_WIDTH-1:0] CODE_ALU_EX_ADD = CTR_BUS_WIDTH'(4'h0);
  localparam logic [CTR_BUS_WIDTH-1:0] CODE_ALU_EX_SUB = CTR_BUS_WIDTH'(4'h1);
  localparam logic [CTR_BUS_WIDTH-1:0] CODE_ALU_EX_AND = CTR_BUS_WIDTH'(4'h2);
  localparam logic [CTR_BUS_WIDTH-1:0] CODE_ALU_EX_OR  = CTR_BUS_WIDTH'(4'h3);
  localparam logic [CTR_BUS_WIDTH-1:0] CODE_ALU_EX_XOR = CTR_BUS_WIDTH'(4'h4);
  localparam logic [CTR_BUS_WIDTH-1:0] CODE_ALU_EX_NOR = CTR_BUS_WIDTH'(4'h5);
  localparam logic [CTR_BUS_WIDTH-1:0] CODE_ALU_EX_SLT = CTR_BUS_WIDTH'(4'h6);
  localparam logic [CTR_BUS_WIDTH-1:0] CODE_ALU_EX_SLL = CTR_BUS_WIDTH'(4'h7);
  localparam logic [CTR_BUS_WIDTH-1:0] CODE_ALU_EX_SRL = CTR_BUS_WIDTH'(4'h8);
  localparam logic [CTR_BUS_WIDTH-1:0] CODE_ALU_EX_SRA = CTR_BUS_WIDTH'(4'h9);
  localparam logic [CTR_BUS_WIDTH-1:0] CODE_ALU_EX_NOP = CTR_BUS_WIDTH'(4'hF);

  logic [CTR_BUS_WIDTH-1:0] ctr_q, ctr_d;
  logic [IO_BUS_WIDTH-1:0]  a_q, a_d;
  logic [IO_BUS_WIDTH-1:0]  b_q, b_d;
  logic                     valid_q;
  logic                     illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_inc;

  logic [IO_BUS_WIDTH-1:0] imm_sext, imm_zext, shamt_zext, rs_shamt_zext;

  assign imm_sext      = {{(IO_BUS_WIDTH-16){i_imm[15]}}, i_imm};
  assign imm_zext      = IO_BUS_WIDTH'(i_imm);
  assign shamt_zext    = IO_BUS_WIDTH'(i_shamt);
  assign rs_shamt_zext = IO_BUS_WIDTH'(i_rs_data[4:0]);

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    ctr_d     = CODE_ALU_EX_NOP;
    a_d       = '0;
    b_d       = '0;
    illegal_d = 1'b0;
    unique case (i_opcode)
      6'h00: begin
        unique case (i_funct)
          6'h20, 6'h21: begin ctr_d = CODE_ALU_EX_ADD; a_d = i_rs_data; b_d = i_rt_data; end
          6'h22, 6'h23: begin ctr_d = CODE_ALU_EX_SUB; a_d = i_rs_data; b_d = i_rt_data; end
          6'h24: begin ctr_d = CODE_ALU_EX_AND; a_d = i_rs_data; b_d = i_rt_data; end
          6'h25: begin ctr_d = CODE_ALU_EX_OR;  a_d = i_rs_data; b_d = i_rt_data; end
          6'h26: begin ctr_d = CODE_ALU_EX_XOR; a_d = i_rs_data; b_d = i_rt_data; end
          6'h27: begin ctr_d = CODE_ALU_EX_NOR; a_d = i_rs_data; b_d = i_rt_data; end
          6'h2A: begin ctr_d = CODE_ALU_EX_SLT; a_d = i_rs_data; b_d = i_rt_data; end
          6'h00: begin ctr_d = CODE_ALU_EX_SLL; a_d = i_rt_data; b_d = shamt_zext; end
          6'h02: begin ctr_d = CODE_ALU_EX_SRL; a_d = i_rt_data; b_d = shamt_zext; end
          6'h03: begin ctr_d = CODE_ALU_EX_SRA; a_d = i_rt_data; b_d = shamt_zext; end
          6'h04: begin ctr_d = CODE_ALU_EX_SLL; a_d = i_rt_data; b_d = rs_shamt_zext; end
          6'h06: begin ctr_d = CODE_ALU_EX_SRL; a_d = i_rt_data; b_d = rs_shamt_zext; end
          6'h07: begin ctr_d = CODE_ALU_EX_SRA; a_d = i_rt_data; b_d = rs_shamt_zext; end
          6'h08, 6'h09: ;
          default: illegal_d = 1'b1;
        endcase
      end
      6'h08, 6'h09,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
      6'h28, 6'h29, 6'h2A, 6'h2B: begin
        ctr_d = CODE_ALU_EX_ADD; a_d = i_rs_data; b_d = imm_sext;
      end
      6'h0A: begin ctr_d = CODE_ALU_EX_SLT; a_d = i_rs_data; b_d = imm_sext; end
      6'h0C: begin ctr_d = CODE_ALU_EX_AND; a_d = i_rs_data; b_d = imm_zext; end
      6'h0D: begin ctr_d = CODE_ALU_EX_OR;  a_d = i_rs_data; b_d = imm_zext; end
      6'h0E: begin ctr_d = CODE_ALU_EX_XOR; a_d = i_rs_data; b_d = imm_zext; end
      6'h0F: begin ctr_d = CODE_ALU_EX_SLL; a_d = imm_zext; b_d = IO_BUS_WIDTH'(16); end
      6'h04, 6'h05: begin ctr_d = CODE_ALU_EX_SUB; a_d = i_rs_data; b_d = i_rt_data; end
      6'h02, 6'h03: ;
      default: illegal_d = 1'b1;
    endcase
  end

  // Priority: reset > flush > stall > load.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      ctr_q     <= CODE_ALU_EX_NOP;
      a_q       <= '0;
      b_q       <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else if (i_flush || (!i_stall && !i_valid)) begin
      ctr_q   <= CODE_ALU_EX_NOP;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= cnt_inc;
    end else if (!i_stall) begin
      ctr_q     <= ctr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      valid_q   <= 1'b1;
      illegal_q <= illegal_q | illegal_d;
    end
  end

  assign o_ctr_code   = ctr_q;
  assign o_data_a     = a_q;
  assign o_data_b     = b_q;
  assign o_valid      = valid_q;
  assign o_illegal    = illegal_q;
  assign o_bubble_cnt = cnt_q;

endmodule

// File: tb/tb_ex_alu_issue.sv
// Scoreboard bench for ex_alu_issue: directed vectors push expected outputs,
// a monitor pops and compares one entry per clock edge.
module tb_ex_alu_issue;

  localparam logic [3:0] C_ADD = 4'h0, C_SUB = 4'h1, C_OR = 4'h3,
                         C_SLL = 4'h7, C_SRA = 4'h9, C_NOP = 4'hF;

  typedef struct {
    logic [3:0]  ctr;
    logic [31:0] a;
    logic [31:0] b;
    logic        v;
    logic        ill;
    logic [15:0] cnt;
    logic [3:0]  cnt_small;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, valid, stall, flush;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] rs, rt;

  logic [3:0]  ctr_o;
  logic [31:0] a_o, b_o;
  logic        v_o, ill_o;
  logic [15:0] cnt_o;

  logic [3:0]  s_ctr_o;
  logic [31:0] s_a_o, s_b_o;
  logic        s_v_o, s_ill_o;
  logic [3:0]  s_cnt_o;

  exp_t exp_q[$];
  exp_t last_e;
  int   m_cnt = 0;
  logic m_ill = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ex_alu_issue #(.IO_BUS_WIDTH(32), .CTR_BUS_WIDTH(4), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_opcode(opcode), .i_funct(funct), .i_shamt(shamt), .i_imm(imm),
    .i_rs_data(rs), .i_rt_data(rt),
    .o_ctr_code(ctr_o), .o_data_a(a_o), .o_data_b(b_o), .o_valid(v_o),
    .o_illegal(ill_o), .o_bubble_cnt(cnt_o)
  );

  ex_alu_issue #(.IO_BUS_WIDTH(32), .CTR_BUS_WIDTH(4), .CNT_WIDTH(4)) dut_small (
    .i_clk(clk), .i_reset(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_opcode(opcode), .i_funct(funct), .i_shamt(shamt), .i_imm(imm),
    .i_rs_data(rs), .i_rt_data(rt),
    .o_ctr_code(s_ctr_o), .o_data_a(s_a_o), .o_data_b(s_b_o), .o_valid(s_v_o),
    .o_illegal(s_ill_o), .o_bubble_cnt(s_cnt_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ctr_code", 32'(ctr_o), 32'(e.ctr));
        chk("data_a", a_o, e.a);
        chk("data_b", b_o, e.b);
        chk("valid", 32'(v_o), 32'(e.v));
        chk("illegal", 32'(ill_o), 32'(e.ill));
        chk("bubble_cnt", 32'(cnt_o), 32'(e.cnt));
        chk("bubble_cnt_sat4", 32'(s_cnt_o), 32'(e.cnt_small));
      end
    end
  end

  task automatic cyc(input logic r, input logic vl, input logic st, input logic fl,
                     input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                     input logic [15:0] im, input logic [31:0] rsd, input logic [31:0] rtd,
                     input logic [3:0] ectr, input logic [31:0] ea, input logic [31:0] eb,
                     input logic eill);
    exp_t e;
    @(negedge clk);
    rst_n = r; valid = vl; stall = st; flush = fl;
    opcode = op; funct = fn; shamt = sh; imm = im; rs = rsd; rt = rtd;
    if (!r) begin
      m_cnt = 0; m_ill = 1'b0;
      e = '{C_NOP, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0, 4'h0};
    end else if (fl || (!st && !vl)) begin
      m_cnt++;
      e = '{C_NOP, 32'h0, 32'h0, 1'b0, m_ill, 16'h0, 4'h0};
    end else if (st) begin
      e = last_e;
    end else begin
      m_ill = m_ill | eill;
      e = '{ectr, ea, eb, 1'b1, m_ill, 16'h0, 4'h0};
    end
    e.cnt       = 16'(m_cnt);
    e.cnt_small = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
    last_e = e;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [15:0] im, input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [3:0] ectr, input logic [31:0] ea, input logic [31:0] eb,
                       input logic eill);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, op, fn, sh, im, rsd, rtd, ectr, ea, eb, eill);
  endtask

  task automatic idle(input logic r, input logic st, input logic fl);
    cyc(r, 1'b0, st, fl, 6'h00, 6'h00, 5'h0, 16'h0, 32'h0, 32'h0, C_NOP, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; stall = 1'b0; flush = 1'b0;
    opcode = '0; funct = '0; shamt = '0; imm = '0; rs = '0; rt = '0;
    last_e = '{C_NOP, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0, 4'h0};

    idle(1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0);

    issue(6'h00, 6'h20, 5'd0, 16'h0, 32'h5, 32'hFFFF_FFFD, C_ADD, 32'h5, 32'hFFFF_FFFD, 1'b0);
    issue(6'h00, 6'h22, 5'd0, 16'h0, 32'd10, 32'd3, C_SUB, 32'd10, 32'd3, 1'b0);
    issue(6'h00, 6'h03, 5'd4, 16'h0, 32'h1234, 32'h8000_0000, C_SRA, 32'h8000_0000, 32'd4, 1'b0);
    issue(6'h00, 6'h04, 5'd9, 16'h0, 32'h25, 32'h1, C_SLL, 32'h1, 32'd5, 1'b0);
    issue(6'h08, 6'h00, 5'd0, 16'hFFF0, 32'h100, 32'h0, C_ADD, 32'h100, 32'hFFFF_FFF0, 1'b0);
    issue(6'h0D, 6'h00, 5'd0, 16'hFFF0, 32'h77, 32'h0, C_OR, 32'h77, 32'h0000_FFF0, 1'b0);
    issue(6'h0F, 6'h00, 5'd0, 16'h1234, 32'hABCD, 32'h0, C_SLL, 32'h1234, 32'd16, 1'b0);
    issue(6'h23, 6'h00, 5'd0, 16'h8004, 32'h1000, 32'h0, C_ADD, 32'h1000, 32'hFFFF_8004, 1'b0);
    issue(6'h04, 6'h00, 5'd0, 16'h0010, 32'd7, 32'd7, C_SUB, 32'd7, 32'd7, 1'b0);
    issue(6'h02, 6'h00, 5'd0, 16'h0, 32'h55, 32'h66, C_NOP, 32'h0, 32'h0, 1'b0);
    issue(6'h00, 6'h08, 5'd0, 16'h0, 32'h55, 32'h66, C_NOP, 32'h0, 32'h0, 1'b0);
    idle(1'b1, 1'b0, 1'b0);

    // ADD held through a 3-cycle stall while SUB waits at the input.
    issue(6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd2, C_ADD, 32'd1, 32'd2, 1'b0);
    repeat (3)
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 6'h00, 6'h22, 5'd0, 16'h0, 32'd9, 32'd4, C_SUB, 32'd9, 32'd4, 1'b0);
    issue(6'h00, 6'h22, 5'd0, 16'h0, 32'd9, 32'd4, C_SUB, 32'd9, 32'd4, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 6'h00, 6'h20, 5'd0, 16'h0, 32'd3, 32'd3, C_ADD, 32'd3, 32'd3, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 6'h00, 6'h20, 5'd0, 16'h0, 32'd3, 32'd3, C_ADD, 32'd3, 32'd3, 1'b0);

    issue(6'h3F, 6'h00, 5'd0, 16'h0, 32'h11, 32'h22, C_NOP, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++)
      issue(6'h00, 6'h21, 5'd0, 16'h0, 32'(i), 32'(2 * i), C_ADD, 32'(i), 32'(2 * i), 1'b0);
    idle(1'b1, 1'b1, 1'b1);
    issue(6'h00, 6'h3F, 5'd0, 16'h0, 32'h1, 32'h2, C_NOP, 32'h0, 32'h0, 1'b1);
    idle(1'b0, 1'b1, 1'b1);
    issue(6'h09, 6'h00, 5'd0, 16'h0001, 32'h10, 32'h0, C_ADD, 32'h10, 32'h1, 1'b0);

    for (int i = 0; i < 20; i++) idle(1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
